// File: rtl/sram_ctrl.sv
// Handshake controller for a 1Mx16 asynchronous SRAM: sequences CE/UB/LB/OE/WE
// for one word or byte access at a time and owns the bidirectional data bus.
module sram_ctrl #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Write,
    input  logic [19:0] Addr,
    input  logic [15:0] WData,
    input  logic [1:0]  ByteEn,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] RData,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

    logic [2:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] wdata;
    logic [1:0]  ben, ben_nxt;
    logic        drive;
    logic        accept, wr_nxt, active_nxt;

    assign accept     = (state == S_IDLE) && Req;
    assign ben_nxt    = accept ? ByteEn : ben;
    assign wr_nxt     = (state_nxt == S_WR_SETUP) || (state_nxt == S_WR_PULSE) ||
                        (state_nxt == S_WR_HOLD);
    assign active_nxt = (state_nxt == S_RD) || wr_nxt;

    assign Data = drive ? wdata : 16'hzzzz;

    // A null-byte request parks in DONE with cnt=1 so its Done pulse lands
    // one cycle after accept, with no strobe ever asserted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (Req) begin
                    if (ByteEn == 2'b00) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = 4'd1;
                    end else if (Write) begin
                        state_nxt = S_WR_SETUP;
                    end else begin
                        state_nxt = S_RD;
                        cnt_nxt   = RD_LOAD;
                    end
                end
            end
            S_RD: begin
                if (cnt == 4'd0) state_nxt = S_DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_WR_SETUP: begin
                state_nxt = S_WR_PULSE;
                cnt_nxt   = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (cnt == 4'd0) state_nxt = S_WR_HOLD;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_WR_HOLD: state_nxt = S_DONE;
            S_DONE: begin
                if (cnt == 4'd0) state_nxt = S_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Every output is registered from the next-state decode.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            wdata <= 16'h0000;
            ben   <= 2'b00;
            ADDR  <= 20'h00000;
            RData <= 16'h0000;
            CE    <= 1'b1;
            UB    <= 1'b1;
            LB    <= 1'b1;
            OE    <= 1'b1;
            WE    <= 1'b1;
            drive <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ben   <= ben_nxt;
            if (accept) begin
                ADDR  <= Addr;
                wdata <= WData;
            end
            if ((state == S_RD) && (cnt == 4'd0)) RData <= Data;
            CE    <= !active_nxt;
            OE    <= (state_nxt != S_RD);
            WE    <= (state_nxt != S_WR_PULSE);
            UB    <= !(active_nxt && ben_nxt[1]);
            LB    <= !(active_nxt && ben_nxt[0]);
            drive <= wr_nxt;
            Busy  <= (state_nxt != S_IDLE);
            Done  <= (state_nxt == S_DONE) && (cnt_nxt == 4'd0);
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM behavioural model on the bus, a word-array reference
// model, directed vector table, multi-cycle corner sequences and random traffic.
module tb_sram_ctrl;

    localparam int RD = 2;
    localparam int WR = 2;

    logic        Clk, Reset, Req, Write;
    logic [19:0] Addr;
    logic [15:0] WData;
    logic [1:0]  ByteEn;
    logic        Busy, Done, CE, UB, LB, OE, WE;
    logic [15:0] RData;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    int n_tests = 0;
    int n_fail  = 0;

    sram_ctrl #(.RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Write(Write), .Addr(Addr),
        .WData(WData), .ByteEn(ByteEn), .Busy(Busy), .Done(Done), .RData(RData),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model (64 words, aliased on ADDR[5:0]); drives the bus on reads.
    logic [15:0] smem [0:63];
    logic        mem_init;
    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) smem[i] <= 16'(i * 37 + 'h4000);
        end else if (!CE && !WE) begin
            if (!UB) smem[ADDR[5:0]][15:8] <= Data[15:8];
            if (!LB) smem[ADDR[5:0]][7:0]  <= Data[7:0];
        end
    end
    assign Data = (!CE && !OE && WE) ? smem[ADDR[5:0]] : 16'hzzzz;
    // Bus keeper: with the chip deselected nobody else may drive, so Data reads 0.
    assign Data = CE ? 16'h0000 : 16'hzzzz;

    // Reference model: word array plus last read value.
    logic [15:0] exp_mem [0:63];
    logic [15:0] exp_rdata;

    typedef struct {
        logic        w;
        logic [19:0] a;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic inv_chk();
        chk("inv_oe_drv", 32'(!OE && (CE || !WE)), 32'd0);
        chk("inv_we_ce", 32'(!WE && CE), 32'd0);
        if (CE) chk("bus_hiz", 32'(Data), 32'd0);
    endtask

    task automatic do_op(input logic w, input logic [19:0] a, input logic [15:0] wd,
                         input logic [1:0] be, input int inject);
        int done_j, exp_j, n_act;
        int ce_lo, oe_lo, we_lo, ub_lo, lb_lo;
        done_j = -1; ce_lo = 0; oe_lo = 0; we_lo = 0; ub_lo = 0; lb_lo = 0;
        Write = w; Addr = a; WData = wd; ByteEn = be; Req = 1'b1;
        @(posedge Clk); #1 Req = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge Clk);
            if (j == inject) begin
                Req = 1'b1; Addr = a ^ 20'hFFFFF; Write = !w; ByteEn = 2'b11;
            end else if (j == inject + 1) begin
                Req = 1'b0;
            end
            inv_chk();
            if (!CE) ce_lo++;
            if (!OE) oe_lo++;
            if (!WE) we_lo++;
            if (!UB) ub_lo++;
            if (!LB) lb_lo++;
            if (!OE) chk("rd_bus", 32'(Data), 32'(exp_mem[a[5:0]]));
            if (!WE) chk("wr_bus", 32'(Data), 32'(wd));
            if (Done) begin
                done_j = j;
                break;
            end
        end
        Req = 1'b0;
        exp_j = (be == 2'b00) ? 1 : (w ? WR + 2 : RD);
        n_act = (be == 2'b00) ? 0 : (w ? WR + 2 : RD);
        chk("done_lat", 32'(done_j), 32'(exp_j));
        chk("ce_cycles", 32'(ce_lo), 32'(n_act));
        chk("oe_cycles", 32'(oe_lo), 32'((be != 2'b00 && !w) ? RD : 0));
        chk("we_cycles", 32'(we_lo), 32'((be != 2'b00 && w) ? WR : 0));
        chk("ub_cycles", 32'(ub_lo), 32'(be[1] ? n_act : 0));
        chk("lb_cycles", 32'(lb_lo), 32'(be[0] ? n_act : 0));
        if (be != 2'b00) begin
            if (w) begin
                if (be[1]) exp_mem[a[5:0]][15:8] = wd[15:8];
                if (be[0]) exp_mem[a[5:0]][7:0]  = wd[7:0];
            end else begin
                exp_rdata = exp_mem[a[5:0]];
            end
        end
        chk("rdata", 32'(RData), 32'(exp_rdata));
        chk("addr_out", 32'(ADDR), 32'(a));
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            inv_chk();
            chk("idle_after", 32'({Busy, Done}), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got no summary expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, dn;
        int dc [3];
        logic pb;

        tbl[0] = '{1'b1, 20'h00010, 16'h1234, 2'b11, 16'h0000};
        tbl[1] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 16'h1234};
        tbl[2] = '{1'b1, 20'h00020, 16'hFFFF, 2'b11, 16'h1234};
        tbl[3] = '{1'b1, 20'h00020, 16'hAB00, 2'b10, 16'h1234};
        tbl[4] = '{1'b0, 20'h00020, 16'h0000, 2'b11, 16'hABFF};
        tbl[5] = '{1'b0, 20'h00010, 16'h0000, 2'b00, 16'hABFF};
        tbl[6] = '{1'b1, 20'h00010, 16'hCAFE, 2'b01, 16'hABFF};
        tbl[7] = '{1'b0, 20'h00010, 16'h0000, 2'b01, 16'h12FE};

        for (int i = 0; i < 64; i++) exp_mem[i] = 16'(i * 37 + 'h4000);
        exp_rdata = 16'h0000;
        mem_init = 1'b1;
        Req = 1'b0; Write = 1'b0; Addr = '0; WData = '0; ByteEn = 2'b00;
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #1;
        chk("rst_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
        chk("rst_busy_done", 32'({Busy, Done}), 32'd0);
        chk("rst_rdata", 32'(RData), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_bus", 32'(Data), 32'd0);
        #20;
        @(negedge Clk);
        Reset = 1'b1;
        mem_init = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, -1);
            chk("tbl_rdata", 32'(RData), 32'(tbl[i].exp_rd));
        end

        // Req held high: three back-to-back reads of 1..3.
        Write = 1'b0; ByteEn = 2'b11; Addr = 20'h00001; Req = 1'b1;
        acc = 0; dn = 0; pb = Busy;
        for (int cyc = 0; cyc < 60 && dn < 3; cyc++) begin
            @(negedge Clk);
            inv_chk();
            if (Busy && !pb) begin
                acc++;
                if (acc == 3) Req = 1'b0;
                else          Addr = 20'(acc + 1);
            end
            pb = Busy;
            if (Done) begin
                dc[dn] = cyc;
                chk("b2b_rdata", 32'(RData), 32'(exp_mem[dn + 1]));
                dn++;
            end
        end
        Req = 1'b0;
        chk("b2b_count", 32'(dn), 32'd3);
        if (dn == 3) begin
            chk("b2b_gap1", 32'(dc[1] - dc[0]), 32'(RD + 2));
            chk("b2b_gap2", 32'(dc[2] - dc[1]), 32'(RD + 2));
            exp_rdata = exp_mem[3];
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("b2b_idle", 32'({Busy, Done}), 32'd0);
        end

        // Req pulsed while busy with a write must be ignored.
        do_op(1'b1, 20'h0002A, 16'h5555, 2'b11, 1);

        // Reset in the second WE-low cycle of a write.
        Write = 1'b1; Addr = 20'h00030; WData = 16'h7777; ByteEn = 2'b11; Req = 1'b1;
        @(posedge Clk); #1 Req = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_pre_we", 32'(WE), 32'd0);
        Reset = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
        chk("mid_rst_bus", 32'(Data), 32'd0);
        chk("mid_rst_rdata", 32'(RData), 32'd0);
        chk("mid_rst_busy_done", 32'({Busy, Done}), 32'd0);
        chk("mid_rst_addr", 32'(ADDR), 32'd0);
        @(posedge Clk); #1 Reset = 1'b1;
        exp_rdata = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            inv_chk();
            chk("post_rst_idle", 32'({Busy, Done}), 32'd0);
        end
        do_op(1'b1, 20'h00030, 16'h0F0F, 2'b11, -1);
        do_op(1'b0, 20'h00010, 16'h0000, 2'b11, -1);
        chk("post_rst_read", 32'(RData), 32'h12FE);

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom_range(0, 1)), 20'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
